platform_table_loader: RTL and testbench

- Sequences level geometry from a synchronous level ROM into the 16-entry ground and 16-entry fence descriptor tables consumed by the pixel colour mapper.
- Started by the game FSM on level entry; raises busy while loading and pulses done when complete.
- Table outputs are registered, so the colour mapper always sees a stable and complete set of entries.

---
 rtl/platform_table_loader.sv | 159 +++++++++++++++
 tb/tb_platform_table_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/platform_table_loader.sv
// Copies 32 level-ROM words into the 16-entry ground and fence descriptor tables.
// Optional TABLE_DBUF_EN: load into shadow tables, publish them on the first frame_start after the load.
module platform_table_loader #(
  parameter int unsigned LEVEL_BITS  = 2,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [LEVEL_BITS-1:0]   i_level,
  input  logic                    i_clear,
  input  logic                    i_frame_start,
  output logic [LEVEL_BITS+4:0]   o_rom_addr,
  input  logic [28:0]             i_rom_data,
  output logic [16*29-1:0]        o_info_ground,
  output logic [16*29-1:0]        o_info_fence,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned ENT_W     = 29;
  localparam int unsigned N_ENT     = 16;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned WAIT_LAST = (ROM_LATENCY > 1) ? ROM_LATENCY - 2 : 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
`ifdef TABLE_DBUF_EN
    ST_COMMIT = 3'd4,
`endif
    ST_DONE   = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_idx;
  logic [LEVEL_BITS-1:0]   r_level_q;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic [ENT_W-1:0]        r_ground [N_ENT];
  logic [ENT_W-1:0]        r_fence  [N_ENT];
`ifdef TABLE_DBUF_EN
  logic [ENT_W-1:0]        r_sh_ground [N_ENT];
  logic [ENT_W-1:0]        r_sh_fence  [N_ENT];
`else
  logic                    w_unused_fs;
  assign w_unused_fs = i_frame_start;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_next = ST_ADDR;
      ST_ADDR:   w_next = (ROM_LATENCY > 1) ? ST_WAIT : ST_WRITE;
      ST_WAIT:   if (r_wait_cnt == CNT_W'(WAIT_LAST)) w_next = ST_WRITE;
      ST_WRITE: begin
        if (r_idx == IDX_W'(31)) begin
`ifdef TABLE_DBUF_EN
          w_next = ST_COMMIT;
`else
          w_next = ST_DONE;
`endif
        end else begin
          w_next = ST_ADDR;
        end
      end
`ifdef TABLE_DBUF_EN
      ST_COMMIT: if (i_frame_start) w_next = ST_DONE;
`endif
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Index, level capture, wait counter, tables and registered status
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx      <= '0;
      r_level_q  <= '0;
      r_wait_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int k = 0; k < N_ENT; k++) begin
        r_ground[k] <= '0;
        r_fence[k]  <= '0;
`ifdef TABLE_DBUF_EN
        r_sh_ground[k] <= '0;
        r_sh_fence[k]  <= '0;
`endif
      end
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_level_q <= i_level;
            r_idx     <= '0;
          end else if (i_clear) begin
            for (int k = 0; k < N_ENT; k++) begin
              r_ground[k] <= '0;
              r_fence[k]  <= '0;
`ifdef TABLE_DBUF_EN
              r_sh_ground[k] <= '0;
              r_sh_fence[k]  <= '0;
`endif
            end
          end
        end
        ST_ADDR: r_wait_cnt <= '0;
        ST_WAIT: r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        ST_WRITE: begin
          // idx[4] selects the fence half of the ROM block
`ifdef TABLE_DBUF_EN
          if (r_idx[4]) r_sh_fence[r_idx[3:0]]  <= i_rom_data;
          else          r_sh_ground[r_idx[3:0]] <= i_rom_data;
`else
          if (r_idx[4]) r_fence[r_idx[3:0]]  <= i_rom_data;
          else          r_ground[r_idx[3:0]] <= i_rom_data;
`endif
          if (r_idx != IDX_W'(31)) r_idx <= r_idx + IDX_W'(1);
        end
`ifdef TABLE_DBUF_EN
        ST_COMMIT: begin
          if (i_frame_start) begin
            for (int k = 0; k < N_ENT; k++) begin
              r_ground[k] <= r_sh_ground[k];
              r_fence[k]  <= r_sh_fence[k];
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_ENT; g++) begin : g_flat
    assign o_info_ground[g*ENT_W +: ENT_W] = r_ground[g];
    assign o_info_fence[g*ENT_W +: ENT_W]  = r_fence[g];
  end

  assign o_rom_addr = {r_level_q, r_idx};
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_platform_table_loader.sv
// Directed bench for platform_table_loader: two instances (ROM latency 1 and 3) with ROM models and
// a scoreboard of expected table words per load. Honours TABLE_DBUF_EN when defined.
module tb_platform_table_loader;

  localparam int unsigned TW = 16*29;
`ifdef TABLE_DBUF_EN
  localparam int DBUF = 1;
`else
  localparam int DBUF = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1, start1, clear1, fs1;
  logic [1:0]    lvl1;
  logic [6:0]    addr1;
  logic [28:0]   data1;
  logic [TW-1:0] g1, f1;
  logic          busy1, done1;

  logic          rst3, start3, clear3, fs3;
  logic [1:0]    lvl3;
  logic [6:0]    addr3;
  logic [28:0]   data3, p3a, p3b;
  logic [TW-1:0] g3, f3;
  logic          busy3, done3;

  platform_table_loader #(.LEVEL_BITS(2), .ROM_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst1), .i_start(start1), .i_level(lvl1), .i_clear(clear1),
    .i_frame_start(fs1), .o_rom_addr(addr1), .i_rom_data(data1),
    .o_info_ground(g1), .o_info_fence(f1), .o_busy(busy1), .o_done(done1));

  platform_table_loader #(.LEVEL_BITS(2), .ROM_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_reset(rst3), .i_start(start3), .i_level(lvl3), .i_clear(clear3),
    .i_frame_start(fs3), .o_rom_addr(addr3), .i_rom_data(data3),
    .o_info_ground(g3), .o_info_fence(f3), .o_busy(busy3), .o_done(done3));

  function automatic logic [28:0] rom_word(input logic [6:0] a);
    return {a, 15'h0, a};
  endfunction

  // Synchronous ROMs with 1 and 3 cycles of latency
  always @(posedge clk) data1 <= rom_word(addr1);
  always @(posedge clk) begin
    p3a   <= rom_word(addr3);
    p3b   <= p3a;
    data3 <= p3b;
  end

  int n_done1 = 0;
  int n_done3 = 0;
  always @(posedge clk) begin
    if (done1) n_done1 <= n_done1 + 1;
    if (done3) n_done3 <= n_done3 + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [28:0] q1[$];
  logic [28:0] q3[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input bit to3, input logic [1:0] lv);
    for (int i = 0; i < 32; i++) begin
      if (to3) q3.push_back(rom_word({lv, 5'(i)}));
      else     q1.push_back(rom_word({lv, 5'(i)}));
    end
  endtask

  // Pop one load's worth of expected words and compare against the live tables
  task automatic sb_check(input bit from3, input string tag);
    logic [28:0] e;
    logic [TW-1:0] g, f;
    g = from3 ? g3 : f1;
    g = from3 ? g3 : g1;
    f = from3 ? f3 : f1;
    for (int i = 0; i < 32; i++) begin
      if (from3 ? (q3.size() == 0) : (q1.size() == 0)) begin
        chk({tag, ".sb_underflow"}, 64'(i), 64'd32);
        return;
      end
      e = from3 ? q3.pop_front() : q1.pop_front();
      if (i < 16) chk($sformatf("%s.ground[%0d]", tag, i), 64'(g[i*29 +: 29]), 64'(e));
      else        chk($sformatf("%s.fence[%0d]", tag, i-16), 64'(f[(i-16)*29 +: 29]), 64'(e));
    end
  endtask

  task automatic load1(input logic [1:0] lv, input bit repulse, input bit with_clear, input string tag);
    int c;
    int nd0;
    nd0    = n_done1;
    start1 = 1'b1;
    clear1 = with_clear;
    lvl1   = lv;
    push_load(1'b0, lv);
    tick();
    start1 = 1'b0;
    clear1 = 1'b0;
    lvl1   = lv + 2'd1;
    c = 1;
    chk({tag, ".busy_c1"}, 64'(busy1), 64'd1);
    chk({tag, ".addr_c1"}, 64'(addr1), 64'({lv, 5'd0}));
    if (with_clear) chk({tag, ".clear_ignored"}, 64'(g1 != '0), 64'd1);
    while (!done1 && c < 2000) begin
      if (repulse && c == 20) begin start1 = 1'b1; lvl1 = 2'd1; end
      else start1 = 1'b0;
      tick();
      c++;
    end
    start1 = 1'b0;
    chk({tag, ".done_cycle"}, 64'(c), 64'(65 + DBUF));
    sb_check(1'b0, tag);
    tick();
    chk({tag, ".done_low"}, 64'(done1), 64'd0);
    chk({tag, ".busy_low"}, 64'(busy1), 64'd0);
    chk({tag, ".done_pulses"}, 64'(n_done1 - nd0), 64'd1);
  endtask

  initial begin
    int c;
    int nd0;
    rst1 = 1'b1; start1 = 1'b0; clear1 = 1'b0; fs1 = 1'b1; lvl1 = 2'd0;
    rst3 = 1'b1; start3 = 1'b0; clear3 = 1'b0; fs3 = 1'b1; lvl3 = 2'd0;
    tick(); tick(); tick();
    rst1 = 1'b0; rst3 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("reset.ground", 64'(g1 == '0), 64'd1);
    chk("reset.fence",  64'(f1 == '0), 64'd1);
    chk("reset.busy",   64'(busy1), 64'd0);
    chk("reset.done",   64'(done1), 64'd0);
    chk("reset.addr",   64'(addr1), 64'd0);
    chk("reset3.addr",  64'(addr3), 64'd0);

    // Level 2 with a second start (level 1) at cycle 20 that must be ignored
    load1(2'd2, 1'b1, 1'b0, "lvl2");
    chk("lvl2.ground5", 64'(g1[5*29 +: 29]), 64'(rom_word(7'h45)));
    chk("lvl2.fence15", 64'(f1[15*29 +: 29]), 64'(rom_word(7'h5F)));
    for (int i = 0; i < 80; i++) tick();
    chk("lvl2.no_requeue", 64'(busy1), 64'd0);

    // Reset asserted at cycle 30 of a load
    nd0 = n_done1;
    start1 = 1'b1; lvl1 = 2'd3;
    push_load(1'b0, 2'd3);
    tick();
    start1 = 1'b0;
    c = 1;
    while (c < 30) begin tick(); c++; end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    q1.delete();
    chk("midrst.ground", 64'(g1 == '0), 64'd1);
    chk("midrst.fence",  64'(f1 == '0), 64'd1);
    chk("midrst.busy",   64'(busy1), 64'd0);
    chk("midrst.addr",   64'(addr1), 64'd0);
    for (int i = 0; i < 100; i++) tick();
    chk("midrst.no_done", 64'(n_done1 - nd0), 64'd0);
    load1(2'd1, 1'b0, 1'b0, "after_rst");

`ifdef TABLE_DBUF_EN
    // Hold off frame_start: live tables keep level 1 until the commit
    fs1 = 1'b0;
    nd0 = n_done1;
    start1 = 1'b1; lvl1 = 2'd0;
    push_load(1'b0, 2'd0);
    tick();
    start1 = 1'b0;
    for (int i = 1; i < 264; i++) tick();
    chk("dbuf.busy_hold", 64'(busy1), 64'd1);
    chk("dbuf.no_done",   64'(n_done1 - nd0), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("dbuf.old_ground[%0d]", i), 64'(g1[i*29 +: 29]), 64'(rom_word({2'd1, 5'(i)})));
      chk($sformatf("dbuf.old_fence[%0d]", i), 64'(f1[i*29 +: 29]), 64'(rom_word({2'd1, 5'(i + 16)})));
    end
    fs1 = 1'b1;
    tick();
    chk("dbuf.done", 64'(done1), 64'd1);
    sb_check(1'b0, "dbuf");
    tick();
    chk("dbuf.done_low", 64'(done1), 64'd0);
`endif

    // start and clear together: start wins
    load1(2'd3, 1'b0, 1'b1, "start_clear");

    // clear in IDLE zeroes the live tables without a done pulse
    nd0 = n_done1;
    clear1 = 1'b1;
    tick();
    clear1 = 1'b0;
    chk("clear.ground", 64'(g1 == '0), 64'd1);
    chk("clear.fence",  64'(f1 == '0), 64'd1);
    chk("clear.busy",   64'(busy1), 64'd0);
    tick();
    chk("clear.no_done", 64'(n_done1 - nd0), 64'd0);

    // ROM latency 3: each WRITE must capture the current address's word
    nd0 = n_done3;
    start3 = 1'b1; lvl3 = 2'd2;
    push_load(1'b1, 2'd2);
    tick();
    start3 = 1'b0; lvl3 = 2'd0;
    c = 1;
    chk("lat3.busy_c1", 64'(busy3), 64'd1);
    while (!done3 && c < 2000) begin tick(); c++; end
    chk("lat3.done_cycle", 64'(c), 64'(129 + DBUF));
    sb_check(1'b1, "lat3");
    tick();
    chk("lat3.busy_low", 64'(busy3), 64'd0);
    chk("lat3.done_pulses", 64'(n_done3 - nd0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
